uart_tx_serializer: RTL

UART transmitter that serializes byte-wide data from the SOC core onto the `TXD` line. It is the transmit counterpart of the board-side serial link: the core hands it a byte via a valid/ready handshake, and it emits one 8-N-1 (optionally parity) frame per byte at a fixed bit period. It sits between the SOC's memory-mapped UART register and the top-level `TXD` pin.

---
 rtl/uart_tx_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one start bit, eight data bits LSB first, optional parity, one stop bit.
// Each byte is taken with a valid/ready handshake, and a new byte can follow the previous stop bit with no gap.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       TXD
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          last;
    logic          accept;
    logic          load;

    assign last   = (cnt_q == LAST);
    assign accept = tx_valid & ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                load    = accept;
            end
            S_START: begin
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    shift_d = shift_q >> 1;
                    par_d   = par_q ^ shift_q[0];
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        if (PAR_EN) begin
                            state_d = S_PAR;
                            txd_d   = par_q ^ shift_q[0];
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end
            S_PAR: begin
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                cnt_d = last ? '0 : cnt_q + CW'(1);
                // Open the handshake one cycle early so a queued byte starts with no gap
                if (cnt_q == PRE) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
                if (last) begin
                    state_d = S_IDLE;
                    load    = accept;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
        if (load) begin
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = tx_data;
            par_d   = PAR_ODD;
            txd_d   = 1'b0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign TXD      = txd_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule
